// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: 2-read/1-write register file with a self-timed clear sequencer.
// Define REGFILE_WRITE_BYPASS_EN to forward same-cycle write data to the read ports.
module reg_file_2r1w #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);
    localparam int N = 2**ADDR_W;
    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_e;
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_q [N];
    logic              wr_en;
    assign wr_en = we && state_q != CLEAR;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    // The counter wraps on the terminal address, but the FSM has already left CLEAR by then
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                state_d = clr_req ? CLEAR : IDLE;
                cnt_d   = '0;
            end
            CLEAR: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = &cnt_q ? DONE : CLEAR;
            end
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        clr_busy = state_q == CLEAR;
        clr_done = state_q == DONE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) mem_q[i] <= '0;
        end else if (state_q == CLEAR) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_en) begin
            mem_q[waddr] <= wdata;
        end
    end
`ifdef REGFILE_WRITE_BYPASS_EN
    assign rdata_a = (rst_n && wr_en && raddr_a == waddr) ? wdata : mem_q[raddr_a];
    assign rdata_b = (rst_n && wr_en && raddr_b == waddr) ? wdata : mem_q[raddr_b];
`else
    assign rdata_a = mem_q[raddr_a];
    assign rdata_b = mem_q[raddr_b];
`endif
endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb_reg_file_2r1w: directed checks of reads, writes and the clear sequencer of reg_file_2r1w.
module tb_reg_file_2r1w;
    localparam int DW = 32;
    localparam int AW = 6;
    logic          clk = 1'b0, rst_n = 1'b0, we = 1'b0, clr_req = 1'b0;
    logic [AW-1:0] waddr = '0, raddr_a = '0, raddr_b = '0;
    logic [DW-1:0] wdata = '0, rdata_a, rdata_b;
    logic          clr_busy, clr_done;
    int            n_run = 0, n_fail = 0;
    int            busy, dones, done_at, seen;
    logic [DW-1:0] mid_a, mid_b;

    always #5 clk = ~clk;

    reg_file_2r1w #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rdata_a), .raddr_b(raddr_b), .rdata_b(rdata_b),
        .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
    );

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        we = 1'b1; waddr = a; wdata = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic read(input logic [AW-1:0] a, input logic [AW-1:0] b);
        raddr_a = a; raddr_b = b;
        #1;
    endtask

    // Pulses clr_req, then watches 70 cycles; tries port writes to 60 and 5 early in CLEAR
    task automatic run_clear(output int nb, output int nd, output int at,
                             output logic [DW-1:0] ma, output logic [DW-1:0] mb);
        nb = 0; nd = 0; at = -1; ma = 'x; mb = 'x;
        @(negedge clk);
        clr_req = 1'b1; raddr_a = 6'd31; raddr_b = 6'd40;
        @(negedge clk);
        clr_req = 1'b0;
        for (int i = 0; i < 70; i++) begin
            if (i == 10) begin we = 1'b1; waddr = 6'd60; wdata = 32'h1234; end
            if (i == 11) begin waddr = 6'd5; end
            if (i == 12) we = 1'b0;
            #1;
            if (clr_busy) nb++;
            if (clr_done) begin nd++; at = i; end
            if (i == 32) begin ma = rdata_a; mb = rdata_b; end
            @(negedge clk);
        end
    endtask

    task automatic wait_done(output int got);
        got = 0;
        for (int i = 0; i < 100 && got == 0; i++) begin
            @(negedge clk);
            if (clr_done) got = 1;
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        read(6'd5, 6'd63);
        check("rst_rd_a", rdata_a, 0);
        check("rst_rd_b", rdata_b, 0);
        check("rst_busy", 32'(clr_busy), 0);
        check("rst_done", 32'(clr_done), 0);
        rst_n = 1'b1;
        read(6'd5, 6'd63);
        check("post_rst_a", rdata_a, 0);
        check("post_rst_b", rdata_b, 0);

        @(negedge clk);
        we = 1'b1; waddr = 6'd7; wdata = 32'hDEADBEEF;
        read(6'd7, 6'd8);
`ifdef REGFILE_WRITE_BYPASS_EN
        check("bypass_a", rdata_a, 32'hDEADBEEF);
`else
        check("no_bypass_a", rdata_a, 0);
`endif
        check("bypass_other_b", rdata_b, 0);
        @(negedge clk);
        we = 1'b0;
        read(6'd7, 6'd7);
        check("wr_rd_a", rdata_a, 32'hDEADBEEF);
        check("wr_rd_b", rdata_b, 32'hDEADBEEF);
        write(6'd63, 32'hCAFE0063);
        write(6'd0, 32'h0000F00D);
        read(6'd0, 6'd63);
        check("reg0_a", rdata_a, 32'h0000F00D);
        check("reg63_b", rdata_b, 32'hCAFE0063);

        write(6'd3, 32'd1);
        write(6'd40, 32'd2);
        run_clear(busy, dones, done_at, mid_a, mid_b);
        check("clr_busy_cycles", 32'(busy), 64);
        check("clr_done_pulses", 32'(dones), 1);
        check("clr_done_cycle", 32'(done_at), 64);
        check("mid_cleared_31", mid_a, 0);
        check("mid_old_40", mid_b, 2);
        read(6'd3, 6'd40);
        check("clr_reg3", rdata_a, 0);
        check("clr_reg40", rdata_b, 0);
        read(6'd60, 6'd5);
        check("clr_wr_ign_60", rdata_a, 0);
        check("clr_wr_ign_5", rdata_b, 0);
        read(6'd7, 6'd63);
        check("clr_reg7", rdata_a, 0);
        check("clr_reg63", rdata_b, 0);

        @(negedge clk);
        we = 1'b1; waddr = 6'd0; wdata = 32'hA5; clr_req = 1'b1;
        @(negedge clk);
        we = 1'b0; clr_req = 1'b0;
        read(6'd0, 6'd0);
        check("sim_wr_reg0", rdata_a, 32'hA5);
        check("sim_wr_busy", 32'(clr_busy), 1);
        @(negedge clk);
        read(6'd0, 6'd1);
        check("sim_wr_cleared", rdata_a, 0);
        wait_done(seen);
        check("sim_wr_done_seen", 32'(seen), 1);

        @(negedge clk);
        clr_req = 1'b1;
        wait_done(seen);
        check("held_done_seen", 32'(seen), 1);
        @(negedge clk);
        check("held_idle_gap", 32'(clr_busy), 0);
        @(negedge clk);
        check("held_restart", 32'(clr_busy), 1);
        clr_req = 1'b0;
        wait_done(seen);
        check("held_done2_seen", 32'(seen), 1);

        write(6'd50, 32'd77);
        @(negedge clk);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        repeat (20) @(negedge clk);
        check("mid_rst_busy_pre", 32'(clr_busy), 1);
        rst_n = 1'b0;
        read(6'd50, 6'd63);
        check("mid_rst_busy", 32'(clr_busy), 0);
        check("mid_rst_reg50", rdata_a, 0);
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (clr_done) seen = 1;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (clr_done || clr_busy) seen = 1;
        end
        check("mid_rst_no_done", 32'(seen), 0);
        write(6'd40, 32'd9);
        run_clear(busy, dones, done_at, mid_a, mid_b);
        check("restart_busy_cycles", 32'(busy), 64);
        check("restart_done_cycle", 32'(done_at), 64);
        check("restart_mid_40", mid_b, 9);
        read(6'd40, 6'd50);
        check("restart_reg40", rdata_a, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
